// File: rtl/sys_pkg.sv
// Shared types and defaults for the systolic-array psum drain path.
package sys_pkg;

    localparam int unsigned SYS_COL_DEF    = 16;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned PSUM_WIDTH_DEF = 2 * DATA_WIDTH_DEF;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned ROW_CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } drain_state_e;

    typedef logic [PSUM_WIDTH_DEF-1:0] psum_t;

endpackage

// File: rtl/sys_psum_drain_if.sv
// Array-side psum capture and downstream row handshake of the psum drain.
interface sys_psum_drain_if #(
    parameter int unsigned SYS_COL    = 16,
    parameter int unsigned PSUM_WIDTH = 32
);
    logic [PSUM_WIDTH-1:0] psum_in  [SYS_COL];
    logic [SYS_COL-1:0]    en_in;
    logic [PSUM_WIDTH-1:0] out_data [SYS_COL];
    logic                  out_valid;
    logic                  out_ready;

    // Environment side: drives the array psums and the downstream ready.
    modport master (
        output psum_in, en_in, out_ready,
        input  out_data, out_valid
    );

    // Drain side.
    modport slave (
        input  psum_in, en_in, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/psum_col_fifo.sv
// Single-clock per-column psum FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module psum_col_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             push_drop
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign push_drop = push && !do_push;
    assign dout      = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sys_psum_drain.sv
// Collects column-skewed psums into per-column FIFOs and hands out re-aligned rows.
module sys_psum_drain
    import sys_pkg::*;
#(
    parameter int unsigned SYS_COL    = SYS_COL_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned ROW_CNT_W  = ROW_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ROW_CNT_W-1:0] num_rows,
    sys_psum_drain_if.slave      dif,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int unsigned PSUM_WIDTH = 2 * DATA_WIDTH;

    drain_state_e         state;
    logic [ROW_CNT_W-1:0] rows_q;
    logic [ROW_CNT_W-1:0] pop_cnt;
    logic [SYS_COL-1:0]   col_empty;
    logic [SYS_COL-1:0]   col_full;
    logic [SYS_COL-1:0]   col_drop;
    logic [SYS_COL-1:0]   col_push;
    logic                 row_valid_c;
    logic                 pop_c;
    logic                 clr_c;
    logic                 unused_full;

    assign row_valid_c   = (state == COLLECT) && !(|col_empty);
    assign pop_c         = row_valid_c && dif.out_ready;
    assign clr_c         = (state == IDLE) && start && (num_rows != '0);
    assign col_push      = (state == COLLECT) ? dif.en_in : '0;
    assign dif.out_valid = row_valid_c;
    assign busy          = (state == COLLECT);
    assign done          = (state == DONE);
    assign unused_full   = ^col_full;

    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
        psum_col_fifo #(
            .WIDTH (PSUM_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .clr       (clr_c),
            .push      (col_push[c]),
            .pop       (pop_c),
            .din       (dif.psum_in[c]),
            .dout      (dif.out_data[c]),
            .empty     (col_empty[c]),
            .full      (col_full[c]),
            .push_drop (col_drop[c])
        );
    end

    // Job FSM with the row pop counter and the sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rows_q   <= '0;
            pop_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            state    <= COLLECT;
                            rows_q   <= num_rows;
                            pop_cnt  <= '0;
                            overflow <= 1'b0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                COLLECT: begin
                    if (|col_drop) begin
                        overflow <= 1'b1;
                    end
                    if (pop_c) begin
                        pop_cnt <= pop_cnt + ROW_CNT_W'(1);
                        if (pop_cnt + ROW_CNT_W'(1) == rows_q) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_psum_drain.sv
// Scoreboard bench for sys_psum_drain: expected rows queued at stimulus, checked on each pop.
module tb_sys_psum_drain;
    import sys_pkg::*;

    localparam int unsigned SYS_COL    = 16;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned PW         = 2 * DATA_WIDTH;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ROW_CNT_W  = 16;

    typedef logic [SYS_COL*PW-1:0] row_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start;
    logic [ROW_CNT_W-1:0] num_rows;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   rows_seen = 0;
    row_t exp_q[$];

    sys_psum_drain_if #(.SYS_COL(SYS_COL), .PSUM_WIDTH(PW)) dif ();

    sys_psum_drain #(
        .SYS_COL    (SYS_COL),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ROW_CNT_W  (ROW_CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .num_rows (num_rows),
        .dif      (dif),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic row_t make_row(input int k);
        row_t r;
        for (int c = 0; c < int'(SYS_COL); c++) begin
            r[c*PW +: PW] = psum_t'(100 * k + c);
        end
        return r;
    endfunction

    // Row scoreboard: every accepted row must match the oldest expected row.
    always @(negedge clk) begin
        if (rstn && dif.out_valid && dif.out_ready) begin
            rows_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_row", 64'(rows_seen), 64'(0));
            end else begin
                row_t e;
                e = exp_q.pop_front();
                for (int c = 0; c < int'(SYS_COL); c++) begin
                    chk($sformatf("row%0d_col%0d", rows_seen, c),
                        64'(dif.out_data[c]), 64'(e[c*PW +: PW]));
                end
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_in_done", 64'(busy), 64'(0));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        dif.en_in = '0;
        for (int c = 0; c < int'(SYS_COL); c++) dif.psum_in[c] = '0;
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        num_rows = ROW_CNT_W'(n);
        step();
        start    = 1'b0;
    endtask

    // Skewed array stream: column c carries row k at cycle c+k.
    task automatic stream(input int nrows, input int last_t);
        for (int t = 0; t <= last_t; t++) begin
            dif.en_in = '0;
            for (int c = 0; c < int'(SYS_COL); c++) begin
                int k;
                k = t - c;
                if (k >= 0 && k < nrows) begin
                    dif.en_in[c]   = 1'b1;
                    dif.psum_in[c] = psum_t'(100 * k + c);
                end
            end
            if (t < nrows) exp_q.push_back(make_row(t));
            if (t == int'(SYS_COL) - 1) chk("valid_early", 64'(dif.out_valid), 64'(0));
            if (t == int'(SYS_COL))     chk("valid_rise", 64'(dif.out_valid), 64'(1));
            step();
        end
        clear_in();
    endtask

    task automatic push_row(input logic [SYS_COL-1:0] en, input int k, input bit expect_row);
        dif.en_in = en;
        for (int c = 0; c < int'(SYS_COL); c++) dif.psum_in[c] = psum_t'(100 * k + c);
        if (expect_row) exp_q.push_back(make_row(k));
        step();
        clear_in();
    endtask

    task automatic wait_done(input int prev, input string tag);
        for (int i = 0; i < 60; i++) begin
            if (done_cnt > prev) break;
            step();
        end
        chk(tag, 64'(done_cnt - prev), 64'(1));
    endtask

    initial begin
        int prev;
        int rs;

        rstn          = 1'b1;
        start         = 1'b0;
        num_rows      = '0;
        dif.out_ready = 1'b0;
        clear_in();
        #1 rstn = 1'b0;
        #20;
        chk("rst_valid", 64'(dif.out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_data", 64'(dif.out_data[0]), 64'(0));
        step();
        rstn = 1'b1;
        step();

        // Skewed stream, downstream always ready.
        dif.out_ready = 1'b1;
        prev = done_cnt;
        rs   = rows_seen;
        do_start(3);
        chk("t1_busy", 64'(busy), 64'(1));
        stream(3, 3 + int'(SYS_COL) - 2);
        wait_done(prev, "t1_done");
        step(); step(); step();
        chk("t1_done_once", 64'(done_cnt - prev), 64'(1));
        chk("t1_busy_low", 64'(busy), 64'(0));
        chk("t1_rows", 64'(rows_seen - rs), 64'(3));
        chk("t1_q_empty", 64'(exp_q.size()), 64'(0));

        // Back-pressure: row 0 must hold stable until ready.
        dif.out_ready = 1'b0;
        prev = done_cnt;
        rs   = rows_seen;
        do_start(3);
        stream(3, 3 + int'(SYS_COL) - 2);
        for (int i = 0; i < 6; i++) begin
            chk("t2_hold_valid", 64'(dif.out_valid), 64'(1));
            chk("t2_hold_d0", 64'(dif.out_data[0]), 64'(0));
            chk("t2_hold_dlast", 64'(dif.out_data[SYS_COL-1]), 64'(SYS_COL - 1));
            step();
        end
        chk("t2_no_ovf", 64'(overflow), 64'(0));
        dif.out_ready = 1'b1;
        wait_done(prev, "t2_done");
        chk("t2_rows", 64'(rows_seen - rs), 64'(3));
        chk("t2_q_empty", 64'(exp_q.size()), 64'(0));

        // Overflow on column 0; its first four entries survive.
        dif.out_ready = 1'b0;
        prev = done_cnt;
        rs   = rows_seen;
        do_start(8);
        for (int i = 0; i < 5; i++) begin
            push_row(SYS_COL'(1), i, 1'b0);
            if (i == 3) chk("t3_ovf_before", 64'(overflow), 64'(0));
            if (i == 4) chk("t3_ovf_set", 64'(overflow), 64'(1));
        end
        chk("t3_head0", 64'(dif.out_data[0]), 64'(0));
        chk("t3_valid_lo", 64'(dif.out_valid), 64'(0));
        for (int k = 0; k < 4; k++) push_row(~SYS_COL'(1), k, 1'b1);
        chk("t3_valid_full", 64'(dif.out_valid), 64'(1));
        dif.out_ready = 1'b1;
        for (int k = 4; k < 8; k++) push_row('1, k, 1'b1);
        wait_done(prev, "t3_done");
        chk("t3_ovf_sticky", 64'(overflow), 64'(1));
        chk("t3_rows", 64'(rows_seen - rs), 64'(8));
        chk("t3_q_empty", 64'(exp_q.size()), 64'(0));

        // Full FIFOs with a same-cycle pop accept the push.
        dif.out_ready = 1'b0;
        prev = done_cnt;
        rs   = rows_seen;
        do_start(6);
        chk("t4_ovf_clr", 64'(overflow), 64'(0));
        for (int k = 0; k < 4; k++) push_row('1, k, 1'b1);
        chk("t4_valid", 64'(dif.out_valid), 64'(1));
        dif.out_ready = 1'b1;
        push_row('1, 4, 1'b1);
        push_row('1, 5, 1'b1);
        chk("t4_no_ovf", 64'(overflow), 64'(0));
        wait_done(prev, "t4_done");
        chk("t4_ovf_end", 64'(overflow), 64'(0));
        chk("t4_rows", 64'(rows_seen - rs), 64'(6));
        chk("t4_q_empty", 64'(exp_q.size()), 64'(0));

        // num_rows=0, IDLE pushes and a start during COLLECT are all ignored.
        chk("t5_kept", 64'(dif.out_data[0]), 64'(200));
        prev     = done_cnt;
        start    = 1'b1;
        num_rows = '0;
        step();
        start    = 1'b0;
        chk("t5_zero_done", 64'(done), 64'(1));
        chk("t5_zero_busy", 64'(busy), 64'(0));
        step();
        chk("t5_done_pulse", 64'(done), 64'(0));
        chk("t5_done_cnt", 64'(done_cnt - prev), 64'(1));
        dif.en_in = '1;
        for (int c = 0; c < int'(SYS_COL); c++) dif.psum_in[c] = PW'(7777);
        step();
        clear_in();
        chk("t5_idle_ignore", 64'(dif.out_data[0]), 64'(200));
        chk("t5_idle_valid", 64'(dif.out_valid), 64'(0));
        prev = done_cnt;
        rs   = rows_seen;
        do_start(1);
        start    = 1'b1;
        num_rows = ROW_CNT_W'(5);
        step();
        start    = 1'b0;
        stream(1, int'(SYS_COL) - 1);
        wait_done(prev, "t5_done");
        chk("t5_rows", 64'(rows_seen - rs), 64'(1));

        // Asynchronous reset after the first of three rows.
        prev = done_cnt;
        rs   = rows_seen;
        do_start(3);
        stream(3, int'(SYS_COL));
        chk("t6_one_row", 64'(rows_seen - rs), 64'(1));
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_valid", 64'(dif.out_valid), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_ovf", 64'(overflow), 64'(0));
        chk("t6_rst_done", 64'(done), 64'(0));
        chk("t6_rst_data", 64'(dif.out_data[0]), 64'(0));
        step(); step();
        rstn = 1'b1;
        step(); step(); step();
        chk("t6_no_done", 64'(done_cnt - prev), 64'(0));
        rs = rows_seen;
        do_start(1);
        stream(1, int'(SYS_COL) - 1);
        wait_done(prev, "t6_done");
        chk("t6_rows", 64'(rows_seen - rs), 64'(1));
        chk("t6_q_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
